// File: rtl/net_arbiter.sv
// net_arbiter: round-robin owner arbiter for one shared net, MAX_HOLD limit.
// Ports: clk, rst (sync, high), req[NUM_REQ], grant, grant_valid, grant_id, preempt; lock with NET_ARB_LOCK_EN.
module net_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW  = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  output logic               preempt
`ifdef NET_ARB_LOCK_EN
  ,
  input  logic               lock
`endif
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [IDW:0] NR = (IDW + 1)'(NUM_REQ);

  state_t               state;
  logic [IDW-1:0]       rr_ptr;
  logic [CW-1:0]        cnt;

  logic [NUM_REQ-1:0]   elig;
  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] shr;
  logic                 win_found;
  logic [IDW-1:0]       off;
  logic [IDW:0]         sum;
  logic [IDW-1:0]       win_idx;
  logic [IDW:0]         nxt;
  logic [IDW-1:0]       nxt_ptr;
  logic [NUM_REQ-1:0]   win_oh;
  logic                 owner_req;
  logic                 at_max;
  logic                 expire;
  logic                 rel;

  // On release the outgoing owner is masked out: a no-op for voluntary
  // release, and the one-arbitration exclusion after preemption.
  always_comb begin
    elig = (state == OWN) ? (req & ~grant) : req;
    dbl = {elig, elig};
    shr = dbl >> rr_ptr;
    win_found = 1'b0;
    off = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && shr[i]) begin
        win_found = 1'b1;
        off = IDW'(i);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    win_idx = (sum >= NR) ? IDW'(sum - NR) : sum[IDW-1:0];
    nxt = {1'b0, win_idx} + (IDW + 1)'(1);
    nxt_ptr = (nxt >= NR) ? IDW'(nxt - NR) : nxt[IDW-1:0];
    win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = (win_idx == IDW'(i));
    end
  end

  assign owner_req = |(req & grant);
  assign at_max    = (cnt == CW'(MAX_HOLD));

`ifdef NET_ARB_LOCK_EN
  assign expire = at_max && !lock;
`else
  assign expire = at_max;
`endif

  assign rel = !owner_req || expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      preempt     <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      preempt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            state       <= OWN;
            grant       <= win_oh;
            grant_valid <= 1'b1;
            grant_id    <= win_idx;
            rr_ptr      <= nxt_ptr;
            cnt         <= CW'(1);
          end
        end
        OWN: begin
          if (rel) begin
            // Simultaneous drop and limit counts as voluntary.
            preempt <= owner_req;
            if (win_found) begin
              grant    <= win_oh;
              grant_id <= win_idx;
              rr_ptr   <= nxt_ptr;
              cnt      <= CW'(1);
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              cnt         <= '0;
            end
          end else if (!at_max) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
